// File: rtl/rob_superscalar_pkg.sv
// Shared configuration, tag type, entry record and lane packet types for the
// superscalar reorder buffer.
package rob_superscalar_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int DP_WIDTH  = 2;
    localparam int RT_WIDTH  = 2;
    localparam int CDB_WIDTH = 2;
    localparam int RD_PORTS  = 4;
    localparam int DATA_W    = 32;
    localparam int AREG_W    = 5;
    localparam int PC_W      = 32;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int CNT_W     = $clog2(ROB_DEPTH + 1);
    localparam int DPF_W     = $clog2(DP_WIDTH + 1);
    localparam int RTC_W     = $clog2(RT_WIDTH + 1);

    // A tag is simply the entry index; every value names a real slot.
    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic              dest_valid;
        logic [AREG_W-1:0] dest_reg;
        logic [DATA_W-1:0] value;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

    typedef struct packed {
        logic              valid;
        logic              dest_valid;
        logic [AREG_W-1:0] dest_reg;
        logic [PC_W-1:0]   pc;
    } dp_lane_t;

    typedef struct packed {
        logic              valid;
        rob_tag_t          tag;
        logic [DATA_W-1:0] value;
    } cdb_lane_t;

    typedef struct packed {
        logic              valid;
        rob_tag_t          tag;
        logic              dest_valid;
        logic [AREG_W-1:0] dest_reg;
        logic [DATA_W-1:0] value;
        logic [PC_W-1:0]   pc;
    } rt_lane_t;

    // Age of a tag relative to a base pointer; wraps naturally at TAG_W bits.
    function automatic rob_tag_t tag_offset(input rob_tag_t tag, input rob_tag_t base);
        return rob_tag_t'(tag - base);
    endfunction

endpackage

// File: rtl/rob_superscalar_if.sv
// Dispatch, completion, squash, operand lookup and retire bundle of the ROB.
// master = the pipeline side driving the ROB, slave = the ROB itself.
interface rob_superscalar_if;
    import rob_superscalar_pkg::*;

    logic [DP_WIDTH-1:0]                dp_valid;
    logic [DP_WIDTH-1:0]                dp_dest_valid;
    logic [DP_WIDTH-1:0][AREG_W-1:0]    dp_dest_reg;
    logic [DP_WIDTH-1:0][PC_W-1:0]      dp_pc;
    logic [DP_WIDTH-1:0][TAG_W-1:0]     dp_tag;
    logic [DPF_W-1:0]                   dp_free;

    logic [CDB_WIDTH-1:0]               cdb_valid;
    logic [CDB_WIDTH-1:0][TAG_W-1:0]    cdb_tag;
    logic [CDB_WIDTH-1:0][DATA_W-1:0]   cdb_value;

    logic                               squash_valid;
    logic [TAG_W-1:0]                   squash_tag;

    logic [RD_PORTS-1:0][TAG_W-1:0]     rd_tag;
    logic [RD_PORTS-1:0]                rd_ready;
    logic [RD_PORTS-1:0][DATA_W-1:0]    rd_value;

    logic [RT_WIDTH-1:0]                rt_valid;
    logic [RT_WIDTH-1:0][TAG_W-1:0]     rt_tag;
    logic [RT_WIDTH-1:0]                rt_dest_valid;
    logic [RT_WIDTH-1:0][AREG_W-1:0]    rt_dest_reg;
    logic [RT_WIDTH-1:0][DATA_W-1:0]    rt_value;
    logic [RT_WIDTH-1:0][PC_W-1:0]      rt_pc;

    modport master (
        output dp_valid, dp_dest_valid, dp_dest_reg, dp_pc,
        output cdb_valid, cdb_tag, cdb_value,
        output squash_valid, squash_tag,
        output rd_tag,
        input  dp_tag, dp_free, rd_ready, rd_value,
        input  rt_valid, rt_tag, rt_dest_valid, rt_dest_reg, rt_value, rt_pc
    );

    modport slave (
        input  dp_valid, dp_dest_valid, dp_dest_reg, dp_pc,
        input  cdb_valid, cdb_tag, cdb_value,
        input  squash_valid, squash_tag,
        input  rd_tag,
        output dp_tag, dp_free, rd_ready, rd_value,
        output rt_valid, rt_tag, rt_dest_valid, rt_dest_reg, rt_value, rt_pc
    );

endinterface

// File: rtl/rob_superscalar_checker.sv
// Protocol checks on the ROB inputs; no functional effect.
module rob_superscalar_checker
    import rob_superscalar_pkg::*;
(
    input logic                            clock,
    input logic                            reset,
    input logic [CDB_WIDTH-1:0]            cdb_valid,
    input logic [CDB_WIDTH-1:0][TAG_W-1:0] cdb_tag,
    input logic                            squash_valid,
    input logic                            squash_hit
);

    // Two broadcast lanes must never complete the same tag in one cycle
    always @(posedge clock) begin
        if (!reset) begin
            for (int a = 0; a < CDB_WIDTH; a++) begin
                for (int b = a + 1; b < CDB_WIDTH; b++) begin
                    assert (!(cdb_valid[a] && cdb_valid[b] && (cdb_tag[a] == cdb_tag[b])));
                end
            end
        end
    end

    // A squash must name an in-flight entry
    always @(posedge clock) begin
        if (!reset) begin
            assert (!squash_valid || squash_hit);
        end
    end

endmodule

// File: rtl/rob_superscalar_retire_select.sv
// In-order retire selection: a lane fires only if it and every older lane in
// the head window hold a finished instruction.
module rob_superscalar_retire_select
    import rob_superscalar_pkg::*;
(
    input  logic [RT_WIDTH-1:0] ready_win,
    input  logic [CNT_W-1:0]    count,
    output logic [RT_WIDTH-1:0] retire_mask,
    output logic [RTC_W-1:0]    retire_cnt
);

    logic [RT_WIDTH:0] run_s;

    // Prefix-AND from the head; the first unfinished entry blocks all younger lanes
    always_comb begin
        run_s       = '0;
        retire_mask = '0;
        retire_cnt  = '0;
        run_s[0]    = 1'b1;
        for (int j = 0; j < RT_WIDTH; j++) begin
            retire_mask[j] = run_s[j] && ready_win[j] && (CNT_W'(j) < count);
            run_s[j+1]     = retire_mask[j];
            retire_cnt     = retire_cnt + RTC_W'(retire_mask[j]);
        end
    end

endmodule

// File: rtl/rob_superscalar.sv
// N-way reorder buffer: circular queue between dispatch and in-order retire,
// with completion broadcasts, operand lookup and single-cycle squash.
module rob_superscalar
    import rob_superscalar_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    rob_superscalar_if.slave rob_bus
);

    rob_entry_t          entry_r   [ROB_DEPTH];
    rob_entry_t          entry_n_s [ROB_DEPTH];
    rob_tag_t            head_r, tail_r, head_n_s, tail_n_s;
    logic [CNT_W-1:0]    count_r, count_n_s, space_s;
    logic [DPF_W-1:0]    dp_free_s, alloc_cnt_s;
    logic [DP_WIDTH-1:0] alloc_mask_s;
    dp_lane_t            dp_pkt_s  [DP_WIDTH];
    cdb_lane_t           cdb_pkt_s [CDB_WIDTH];
    rt_lane_t            rt_pkt_s  [RT_WIDTH];
    rob_tag_t            win_idx_s [RT_WIDTH];
    logic [ROB_DEPTH-1:0] kill_s, drop_s, cdb_hit_s;
    logic [DATA_W-1:0]   cdb_val_s [ROB_DEPTH];
    logic                squash_hit_s;
    rob_tag_t            squash_off_s;
    logic [RT_WIDTH-1:0] ready_win_s, retire_mask_s;
    logic [RTC_W-1:0]    retire_cnt_s;

    // Dispatch credit from current occupancy only, lane tags and accepted lanes
    always_comb begin
        space_s        = CNT_W'(ROB_DEPTH) - count_r;
        dp_free_s      = (space_s >= CNT_W'(DP_WIDTH)) ? DPF_W'(DP_WIDTH) : DPF_W'(space_s);
        alloc_mask_s   = '0;
        alloc_cnt_s    = '0;
        rob_bus.dp_tag = '0;
        for (int i = 0; i < DP_WIDTH; i++) begin
            dp_pkt_s[i].valid      = rob_bus.dp_valid[i];
            dp_pkt_s[i].dest_valid = rob_bus.dp_dest_valid[i];
            dp_pkt_s[i].dest_reg   = rob_bus.dp_dest_reg[i];
            dp_pkt_s[i].pc         = rob_bus.dp_pc[i];
            rob_bus.dp_tag[i]      = tail_r + TAG_W'(i);
            alloc_mask_s[i]        = dp_pkt_s[i].valid && (DPF_W'(i) < dp_free_s);
            alloc_cnt_s            = alloc_cnt_s + DPF_W'(alloc_mask_s[i]);
        end
        rob_bus.dp_free = dp_free_s;
    end

    // Squash qualification and the set of entries strictly younger than the branch
    always_comb begin
        kill_s       = '0;
        squash_hit_s = rob_bus.squash_valid && entry_r[rob_bus.squash_tag].valid;
        squash_off_s = tag_offset(rob_bus.squash_tag, head_r);
        for (int k = 0; k < ROB_DEPTH; k++) begin
            kill_s[k] = squash_hit_s && entry_r[k].valid &&
                        (tag_offset(TAG_W'(k), head_r) > squash_off_s);
        end
    end

    // Head window readiness; a squashed entry can never retire
    always_comb begin
        ready_win_s = '0;
        for (int j = 0; j < RT_WIDTH; j++) begin
            win_idx_s[j]   = head_r + TAG_W'(j);
            ready_win_s[j] = entry_r[win_idx_s[j]].valid && entry_r[win_idx_s[j]].complete &&
                             !kill_s[win_idx_s[j]];
        end
    end

    rob_superscalar_retire_select u_retire_select (
        .ready_win   (ready_win_s),
        .count       (count_r),
        .retire_mask (retire_mask_s),
        .retire_cnt  (retire_cnt_s)
    );

    // Retire lane packets, zeroed on idle lanes
    always_comb begin
        rob_bus.rt_valid      = '0;
        rob_bus.rt_tag        = '0;
        rob_bus.rt_dest_valid = '0;
        rob_bus.rt_dest_reg   = '0;
        rob_bus.rt_value      = '0;
        rob_bus.rt_pc         = '0;
        for (int j = 0; j < RT_WIDTH; j++) begin
            rt_pkt_s[j].valid      = retire_mask_s[j];
            rt_pkt_s[j].tag        = win_idx_s[j];
            rt_pkt_s[j].dest_valid = retire_mask_s[j] && entry_r[win_idx_s[j]].dest_valid;
            rt_pkt_s[j].dest_reg   = retire_mask_s[j] ? entry_r[win_idx_s[j]].dest_reg : '0;
            rt_pkt_s[j].value      = retire_mask_s[j] ? entry_r[win_idx_s[j]].value : '0;
            rt_pkt_s[j].pc         = retire_mask_s[j] ? entry_r[win_idx_s[j]].pc : '0;
            rob_bus.rt_valid[j]      = rt_pkt_s[j].valid;
            rob_bus.rt_tag[j]        = rt_pkt_s[j].tag;
            rob_bus.rt_dest_valid[j] = rt_pkt_s[j].dest_valid;
            rob_bus.rt_dest_reg[j]   = rt_pkt_s[j].dest_reg;
            rob_bus.rt_value[j]      = rt_pkt_s[j].value;
            rob_bus.rt_pc[j]         = rt_pkt_s[j].pc;
        end
    end

    // Operand lookup: value is visible only once the entry is live and finished
    always_comb begin
        rob_bus.rd_ready = '0;
        rob_bus.rd_value = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rob_bus.rd_ready[p] = entry_r[rob_bus.rd_tag[p]].valid && entry_r[rob_bus.rd_tag[p]].complete;
            rob_bus.rd_value[p] = rob_bus.rd_ready[p] ? entry_r[rob_bus.rd_tag[p]].value : '0;
        end
    end

    // Per-entry next state: retire/squash invalidation, broadcast capture, allocation
    always_comb begin
        drop_s    = '0;
        cdb_hit_s = '0;
        for (int c = 0; c < CDB_WIDTH; c++) begin
            cdb_pkt_s[c].valid = rob_bus.cdb_valid[c];
            cdb_pkt_s[c].tag   = rob_bus.cdb_tag[c];
            cdb_pkt_s[c].value = rob_bus.cdb_value[c];
        end
        for (int k = 0; k < ROB_DEPTH; k++) begin
            drop_s[k]    = kill_s[k] ||
                           (tag_offset(TAG_W'(k), head_r) < TAG_W'(retire_cnt_s));
            cdb_val_s[k] = '0;
            for (int c = 0; c < CDB_WIDTH; c++) begin
                cdb_val_s[k] = (cdb_pkt_s[c].valid && (cdb_pkt_s[c].tag == TAG_W'(k))) ?
                               cdb_pkt_s[c].value : cdb_val_s[k];
                cdb_hit_s[k] = cdb_hit_s[k] ||
                               (cdb_pkt_s[c].valid && (cdb_pkt_s[c].tag == TAG_W'(k)));
            end
            cdb_hit_s[k]           = cdb_hit_s[k] && entry_r[k].valid && !drop_s[k];
            entry_n_s[k]            = entry_r[k];
            entry_n_s[k].valid      = entry_r[k].valid && !drop_s[k];
            entry_n_s[k].complete   = entry_r[k].complete || cdb_hit_s[k];
            entry_n_s[k].value      = cdb_hit_s[k] ? cdb_val_s[k] : entry_r[k].value;
            for (int i = 0; i < DP_WIDTH; i++) begin
                entry_n_s[k] = (!squash_hit_s && alloc_mask_s[i] &&
                                (rob_tag_t'(tail_r + TAG_W'(i)) == TAG_W'(k))) ?
                               rob_entry_t'{valid:      1'b1,
                                            complete:   1'b0,
                                            dest_valid: dp_pkt_s[i].dest_valid,
                                            dest_reg:   dp_pkt_s[i].dest_reg,
                                            value:      '0,
                                            pc:         dp_pkt_s[i].pc} :
                               entry_n_s[k];
            end
        end
    end

    // Pointer and occupancy update; a squash rewinds tail and drops this cycle's dispatch
    always_comb begin
        head_n_s = head_r + TAG_W'(retire_cnt_s);
        if (squash_hit_s) begin
            tail_n_s  = rob_bus.squash_tag + TAG_W'(1);
            count_n_s = CNT_W'(squash_off_s) + CNT_W'(1) - CNT_W'(retire_cnt_s);
        end else begin
            tail_n_s  = tail_r + TAG_W'(alloc_cnt_s);
            count_n_s = count_r + CNT_W'(alloc_cnt_s) - CNT_W'(retire_cnt_s);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int k = 0; k < ROB_DEPTH; k++) begin
                entry_r[k] <= '0;
            end
        end else begin
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
            for (int k = 0; k < ROB_DEPTH; k++) begin
                entry_r[k] <= entry_n_s[k];
            end
        end
    end

    rob_superscalar_checker u_checker (
        .clock        (clock),
        .reset        (reset),
        .cdb_valid    (rob_bus.cdb_valid),
        .cdb_tag      (rob_bus.cdb_tag),
        .squash_valid (rob_bus.squash_valid),
        .squash_hit   (squash_hit_s)
    );

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for the reorder buffer: fill, completion order, wrap,
// squash, full-cycle stall and asynchronous reset.
module tb_rob_superscalar;
    import rob_superscalar_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    rob_superscalar_if bus ();

    rob_superscalar dut (
        .clock   (clock),
        .reset   (reset),
        .rob_bus (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input int t);
        return 32'h0000_1000 + 32'(t * 4);
    endfunction

    function automatic logic [4:0] dreg_of(input int t);
        return 5'(t + 1);
    endfunction

    function automatic logic [31:0] val_of(input int t);
        return 32'h0000_A000 + 32'(t);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dp_valid      = '0;
        bus.dp_dest_valid = '0;
        bus.dp_dest_reg   = '0;
        bus.dp_pc         = '0;
        bus.cdb_valid     = '0;
        bus.cdb_tag       = '0;
        bus.cdb_value     = '0;
        bus.squash_valid  = 1'b0;
        bus.squash_tag    = '0;
        bus.rd_tag        = '0;
    endtask

    task automatic drive_dp(input logic [1:0] v, input int t0);
        bus.dp_valid      = v;
        bus.dp_dest_valid = v;
        for (int i = 0; i < DP_WIDTH; i++) begin
            bus.dp_dest_reg[i] = dreg_of((t0 + i) % ROB_DEPTH);
            bus.dp_pc[i]       = pc_of((t0 + i) % ROB_DEPTH);
        end
    endtask

    task automatic drive_cdb(input logic [1:0] v, input int t0, input int t1);
        bus.cdb_valid    = v;
        bus.cdb_tag[0]   = TAG_W'(t0);
        bus.cdb_tag[1]   = TAG_W'(t1);
        bus.cdb_value[0] = val_of(t0);
        bus.cdb_value[1] = val_of(t1);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #12;
        chk("reset_dp_free",  64'(bus.dp_free),  64'd2);
        chk("reset_rt_valid", 64'(bus.rt_valid), 64'd0);
        chk("reset_rd_ready", 64'(bus.rd_ready), 64'd0);
        reset = 1'b0;

        // Fill the buffer two per cycle
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            drive_dp(2'b11, 2 * c);
            #1;
            chk("fill_dp_free", 64'(bus.dp_free),   64'd2);
            chk("fill_tag0",    64'(bus.dp_tag[0]), 64'(2 * c));
            chk("fill_tag1",    64'(bus.dp_tag[1]), 64'(2 * c + 1));
            step();
        end

        // Full: extra dispatch dropped; complete tag1 first
        idle_inputs();
        drive_dp(2'b11, 0);
        drive_cdb(2'b01, 1, 0);
        #1;
        chk("full_dp_free", 64'(bus.dp_free),   64'd0);
        chk("full_count",   64'(dut.count_r),   64'd16);
        step();

        idle_inputs();
        drive_cdb(2'b01, 0, 0);
        bus.rd_tag[0] = 4'd1;
        #1;
        chk("ooo_no_retire", 64'(bus.rt_valid),    64'd0);
        chk("ooo_count",     64'(dut.count_r),     64'd16);
        chk("rd1_ready",     64'(bus.rd_ready[0]), 64'd1);
        chk("rd1_value",     64'(bus.rd_value[0]), 64'(val_of(1)));
        step();

        // Both retire while dispatch at full stalls
        idle_inputs();
        drive_dp(2'b11, 0);
        #1;
        chk("ret01_valid",  64'(bus.rt_valid),       64'd3);
        chk("ret01_tag0",   64'(bus.rt_tag[0]),      64'd0);
        chk("ret01_tag1",   64'(bus.rt_tag[1]),      64'd1);
        chk("ret01_val0",   64'(bus.rt_value[0]),    64'(val_of(0)));
        chk("ret01_val1",   64'(bus.rt_value[1]),    64'(val_of(1)));
        chk("ret01_pc1",    64'(bus.rt_pc[1]),       64'(pc_of(1)));
        chk("ret01_dreg0",  64'(bus.rt_dest_reg[0]), 64'(dreg_of(0)));
        chk("ret01_dvalid", 64'(bus.rt_dest_valid),  64'd3);
        chk("ret01_dpfree", 64'(bus.dp_free),        64'd0);
        step();

        idle_inputs();
        #1;
        chk("after_full_count", 64'(dut.count_r),     64'd14);
        chk("after_full_free",  64'(bus.dp_free),     64'd2);
        chk("after_full_tag0",  64'(bus.dp_tag[0]),   64'd0);
        chk("after_full_rt",    64'(bus.rt_valid),    64'd0);
        chk("rd0_retired",      64'(bus.rd_ready[0]), 64'd0);

        // Drain 2..13 so head lands on 14
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            drive_cdb(2'b11, 2 + 2 * c, 3 + 2 * c);
            #1;
            chk("drain_rt_valid", 64'(bus.rt_valid), (c == 0) ? 64'd0 : 64'd3);
            step();
        end
        idle_inputs();
        drive_dp(2'b11, 0);
        #1;
        chk("drain_last_rt",  64'(bus.rt_valid),  64'd3);
        chk("drain_last_tag", 64'(bus.rt_tag[0]), 64'd12);
        chk("wrap_dp_tag0",   64'(bus.dp_tag[0]), 64'd0);
        step();

        idle_inputs();
        drive_cdb(2'b11, 0, 1);
        #1;
        chk("wrap_head",  64'(dut.head_r),  64'd14);
        chk("wrap_count", 64'(dut.count_r), 64'd4);
        chk("wrap_no_rt", 64'(bus.rt_valid), 64'd0);
        step();

        idle_inputs();
        drive_cdb(2'b11, 14, 15);
        #1;
        chk("wrap_no_rt2", 64'(bus.rt_valid), 64'd0);
        step();

        idle_inputs();
        #1;
        chk("wrap_rt_a",    64'(bus.rt_valid),  64'd3);
        chk("wrap_tag_a0",  64'(bus.rt_tag[0]), 64'd14);
        chk("wrap_tag_a1",  64'(bus.rt_tag[1]), 64'd15);
        chk("wrap_count_a", 64'(dut.count_r),   64'd4);
        step();

        idle_inputs();
        #1;
        chk("wrap_rt_b",    64'(bus.rt_valid),    64'd3);
        chk("wrap_tag_b0",  64'(bus.rt_tag[0]),   64'd0);
        chk("wrap_tag_b1",  64'(bus.rt_tag[1]),   64'd1);
        chk("wrap_val_b1",  64'(bus.rt_value[1]), 64'(val_of(1)));
        chk("wrap_count_b", 64'(dut.count_r),     64'd2);
        chk("wrap_head_b",  64'(dut.head_r),      64'd0);
        step();

        idle_inputs();
        #1;
        chk("empty_count", 64'(dut.count_r),  64'd0);
        chk("empty_head",  64'(dut.head_r),   64'd2);
        chk("empty_rt",    64'(bus.rt_valid), 64'd0);
        chk("empty_free",  64'(bus.dp_free),  64'd2);

        // Move head to 3 with a single-lane dispatch
        drive_dp(2'b01, 2);
        #1;
        chk("single_tag", 64'(bus.dp_tag[0]), 64'd2);
        step();
        idle_inputs();
        drive_cdb(2'b01, 2, 0);
        step();
        idle_inputs();
        #1;
        chk("single_rt",     64'(bus.rt_valid),  64'd1);
        chk("single_rt_tag", 64'(bus.rt_tag[0]), 64'd2);
        step();

        // Entries 3..10, then squash at 5 with dispatch attempted
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            drive_dp(2'b11, 3 + 2 * c);
            step();
        end
        idle_inputs();
        #1;
        chk("pre_squash_count", 64'(dut.count_r), 64'd8);
        bus.squash_valid = 1'b1;
        bus.squash_tag   = 4'd5;
        drive_dp(2'b11, 11);
        #1;
        chk("squash_free", 64'(bus.dp_free), 64'd2);
        step();

        idle_inputs();
        drive_cdb(2'b01, 7, 0);
        bus.rd_tag[0] = 4'd7;
        #1;
        chk("squash_tail",  64'(dut.tail_r),      64'd6);
        chk("squash_count", 64'(dut.count_r),     64'd3);
        chk("squash_rd7",   64'(bus.rd_ready[0]), 64'd0);
        step();

        idle_inputs();
        drive_dp(2'b11, 6);
        bus.rd_tag[0] = 4'd7;
        #1;
        chk("resume_tag0", 64'(bus.dp_tag[0]),   64'd6);
        chk("resume_tag1", 64'(bus.dp_tag[1]),   64'd7);
        chk("resume_rd7",  64'(bus.rd_ready[0]), 64'd0);
        step();

        idle_inputs();
        bus.rd_tag[0] = 4'd7;
        #1;
        chk("resume_count", 64'(dut.count_r),     64'd5);
        chk("resume_tail",  64'(dut.tail_r),      64'd8);
        chk("new7_pending", 64'(bus.rd_ready[0]), 64'd0);

        // Asynchronous reset in the middle of a cycle
        drive_cdb(2'b01, 3, 0);
        step();
        idle_inputs();
        bus.rd_tag[0] = 4'd3;
        #1;
        chk("pre_rst_rd3", 64'(bus.rd_ready[0]), 64'd1);
        chk("pre_rst_rt",  64'(bus.rt_valid),    64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count",    64'(dut.count_r),  64'd0);
        chk("arst_rt_valid", 64'(bus.rt_valid), 64'd0);
        chk("arst_rd_ready", 64'(bus.rd_ready), 64'd0);
        chk("arst_dp_free",  64'(bus.dp_free),  64'd2);
        #3;
        reset = 1'b0;
        step();
        idle_inputs();
        #1;
        chk("post_rst_tag0", 64'(bus.dp_tag[0]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
